// File: rtl/line_word_streamer.sv
// line_word_streamer: captures a cache line and streams a wrapping word burst over valid/ready
//   Optional feature macro: LINE_WORD_STREAMER_ABORT_EN (adds i_abort)
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_line_in             flattened line, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_start               request burst (honoured only when idle)
//   i_start_offset        first word index
//   i_burst_len           word count; 0 or > WORDS_PER_LINE means a full line
//   i_out_ready           consumer accepts current word
//   i_abort               (macro only) drop the burst in progress
//   o_busy, o_out_valid   burst in progress / word valid
//   o_out_data            current word
//   o_out_offset          index of current word
//   o_out_last            current word is the final one
//   o_done                one-cycle pulse after the final word is accepted
module line_word_streamer #(
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 16,
    parameter int OFFSET_WIDTH   = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] i_line_in,
    input  logic                               i_start,
    input  logic [OFFSET_WIDTH-1:0]            i_start_offset,
    input  logic [OFFSET_WIDTH:0]              i_burst_len,
    input  logic                               i_out_ready,
`ifdef LINE_WORD_STREAMER_ABORT_EN
    input  logic                               i_abort,
`endif
    output logic                               o_busy,
    output logic                               o_out_valid,
    output logic [DATA_WIDTH-1:0]              o_out_data,
    output logic [OFFSET_WIDTH-1:0]            o_out_offset,
    output logic                               o_out_last,
    output logic                               o_done
);
    typedef enum logic {S_IDLE, S_STREAM} state_t;
    localparam logic [OFFSET_WIDTH:0]   L_FULL = (OFFSET_WIDTH+1)'(WORDS_PER_LINE);
    localparam logic [OFFSET_WIDTH:0]   L_ONE  = (OFFSET_WIDTH+1)'(1);
    localparam logic [OFFSET_WIDTH-1:0] L_INC  = OFFSET_WIDTH'(1);
    state_t                            r_state, w_state_n;
    logic [DATA_WIDTH*WORDS_PER_LINE-1:0] r_line, w_line_n;
    logic [OFFSET_WIDTH-1:0]           r_idx, w_idx_n;
    logic [OFFSET_WIDTH:0]             r_rem, w_rem_n, w_len;
    logic                              r_done, w_done_n, w_abort;
`ifdef LINE_WORD_STREAMER_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif
    assign w_len = (i_burst_len == '0 || i_burst_len > L_FULL) ? L_FULL : i_burst_len;
    always_comb begin
        w_state_n = r_state;
        w_line_n  = r_line;
        w_idx_n   = r_idx;
        w_rem_n   = r_rem;
        w_done_n  = 1'b0;
        if (r_state == S_IDLE) begin
            if (i_start) begin
                w_state_n = S_STREAM;
                w_line_n  = i_line_in;
                w_idx_n   = i_start_offset;
                w_rem_n   = w_len;
            end
        end else if (w_abort) begin
            // abort wins over a transfer on the same edge and produces no done pulse
            w_state_n = S_IDLE;
        end else if (i_out_ready) begin
            if (r_rem == L_ONE) begin
                w_state_n = S_IDLE;
                w_done_n  = 1'b1;
            end else begin
                w_idx_n = r_idx + L_INC;
                w_rem_n = r_rem - L_ONE;
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_line  <= '0;
            r_idx   <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_line  <= w_line_n;
            r_idx   <= w_idx_n;
            r_rem   <= w_rem_n;
            r_done  <= w_done_n;
        end
    end
    // data comes only from the captured line, never from i_line_in
    assign o_out_data   = r_line[r_idx*DATA_WIDTH +: DATA_WIDTH];
    assign o_busy       = (r_state == S_STREAM);
    assign o_out_valid  = o_busy;
    assign o_out_offset = r_idx;
    assign o_out_last   = o_busy && (r_rem == L_ONE);
    assign o_done       = r_done;
endmodule

// File: tb/tb_line_word_streamer.sv
// tb_line_word_streamer: scoreboard bench for line_word_streamer
module tb_line_word_streamer;
    logic         clk = 0, i_rst = 1, i_start = 0, i_out_ready = 0, i_abort = 0;
    logic [511:0] i_line_in = '0;
    logic [3:0]   i_start_offset = '0;
    logic [4:0]   i_burst_len = '0;
    logic         o_busy, o_out_valid, o_out_last, o_done;
    logic [31:0]  o_out_data;
    logic [3:0]   o_out_offset;
    typedef struct {logic [31:0] d; logic [3:0] o; logic l;} exp_t;
    exp_t q[$];
    int checks = 0, failures = 0;
    logic exp_busy = 0, exp_done = 0, arm = 0;
    line_word_streamer dut (
        .i_clk(clk), .i_rst(i_rst), .i_line_in(i_line_in), .i_start(i_start),
        .i_start_offset(i_start_offset), .i_burst_len(i_burst_len), .i_out_ready(i_out_ready),
`ifdef LINE_WORD_STREAMER_ABORT_EN
        .i_abort(i_abort),
`endif
        .o_busy(o_busy), .o_out_valid(o_out_valid), .o_out_data(o_out_data),
        .o_out_offset(o_out_offset), .o_out_last(o_out_last), .o_done(o_done));
    always #5 clk = ~clk;
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic [511:0] mk_line(logic [31:0] base);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction
    task automatic cyc();
        logic done_n;
        done_n = 0;
        @(negedge clk);
        chk("done", o_done, exp_done);
        chk("valid", o_out_valid, exp_busy);
        chk("busy", o_busy, exp_busy);
        if (exp_busy && o_out_valid && q.size() != 0) begin
            chk("data", o_out_data, q[0].d);
            chk("offset", o_out_offset, q[0].o);
            chk("last", o_out_last, q[0].l);
            if (i_abort) begin
                q.delete();
                exp_busy = 0;
            end else if (i_out_ready) begin
                done_n = q[0].l;
                if (q[0].l) exp_busy = 0;
                void'(q.pop_front());
            end
        end else if (!exp_busy) begin
            chk("last_idle", o_out_last, 0);
        end
        exp_done = done_n;
        @(posedge clk);
        if (i_rst) begin
            q.delete();
            exp_busy = 0;
            exp_done = 0;
        end else if (arm) begin
            exp_busy = 1;
        end
        arm = 0;
        #1;
    endtask
    task automatic start(logic [3:0] off, logic [4:0] len);
        int eff;
        i_start = 1;
        i_start_offset = off;
        i_burst_len = len;
        eff = (len == 0 || len > 16) ? 16 : int'(len);
        for (int k = 0; k < eff; k++) begin
            exp_t e;
            e.o = off + 4'(k);
            e.d = i_line_in[e.o*32 +: 32];
            e.l = (k == eff - 1);
            q.push_back(e);
        end
        arm = 1;
        cyc();
        i_start = 0;
    endtask
    task automatic drain();
        for (int n = 0; n < 40 && (exp_busy || arm || exp_done); n++) cyc();
        chk("drain", {exp_busy, arm, exp_done}, 0);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        i_rst = 0;
        @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", o_out_valid, 0);
        chk("rst_last", o_out_last, 0);
        chk("rst_done", o_done, 0);
        chk("rst_offset", o_out_offset, 0);
        chk("rst_data", o_out_data, 0);
        @(posedge clk);
        #1;
        i_line_in = mk_line(32'h1000);
        i_out_ready = 1;
        start(4'd13, 5'd0);
        drain();
        cyc();
        start(4'd2, 5'd3);
        cyc();
        i_out_ready = 0;
        repeat (4) cyc();
        i_out_ready = 1;
        drain();
        start(4'd0, 5'd8);
        repeat (2) cyc();
        i_start = 1;
        i_start_offset = 4'd7;
        i_burst_len = 5'd1;
        i_line_in = mk_line(32'hBEEF0000);
        repeat (3) cyc();
        i_start = 0;
        repeat (2) cyc();
        i_start = 1;
        cyc();
        i_start = 0;
        drain();
        cyc();
        i_line_in = mk_line(32'h2000);
        start(4'd5, 5'd31);
        drain();
        start(4'd14, 5'd17);
        drain();
        i_line_in = mk_line(32'h1000);
        start(4'd0, 5'd0);
        repeat (2) cyc();
        i_rst = 1;
        cyc();
        i_rst = 0;
        cyc();
        cyc();
`ifdef LINE_WORD_STREAMER_ABORT_EN
        start(4'd0, 5'd0);
        repeat (4) cyc();
        i_abort = 1;
        cyc();
        i_abort = 0;
        cyc();
        i_abort = 1;
        start(4'd0, 5'd2);
        i_abort = 0;
        drain();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
